// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory types for the mem_* blocks
package mem_pkg;

  // Only read-first is implemented; the enum leaves room for write-first/no-change.
  typedef enum logic [0:0] {
    READ_FIRST = 1'b0
  } mem_read_mode_t;

  typedef struct packed {
    logic [31:0] freq_hz;
    logic        is_async;
  } std_clock_info_t;

endpackage

// File: rtl/mem_intf.sv
// rtl/mem_intf.sv - valid/ready memory request/response interface
interface mem_intf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) ();
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic [MASK_WIDTH-1:0] write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport in (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );

  modport out (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );
endinterface

// File: rtl/mem_block_ram_array.sv
// rtl/mem_block_ram_array.sv - inferred lane-writable RAM with a registered read-first port
module mem_block_ram_array
  import mem_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter mem_read_mode_t  READ_MODE  = READ_FIRST,
  parameter int              WIDTH      = 32,
  parameter int              DEPTH      = 256,
  parameter int              LANES      = 4,
  parameter string           INIT_FILE  = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [LANES-1:0]         we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  localparam int LW = WIDTH / LANES;

  if (CLOCK_INFO.is_async) begin : g_clock_check
    $error("mem_block_ram_array supports a single synchronous clock only");
  end
  if (READ_MODE != READ_FIRST) begin : g_mode_check
    $error("mem_block_ram_array implements READ_FIRST only");
  end
  if (WIDTH % LANES != 0) begin : g_lane_check
    $error("WIDTH must be a multiple of LANES");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  // Read samples the old word before the lane writes land: read-first.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
      end
    end
  end
endmodule

// File: rtl/mem_block_ram.sv
// rtl/mem_block_ram.sv - block RAM endpoint with credit-controlled response FIFO
module mem_block_ram
  import mem_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO    = 'b0,
  parameter int              OUTPUT_DEPTH  = 3,
  parameter bit              WRITE_RESPOND = 1'b0,
  parameter string           INIT_FILE     = ""
) (
  input logic  clk,
  input logic  rst,
  mem_intf.in  mem_in,
  mem_intf.out mem_out
);
  localparam int AW = mem_in.ADDR_WIDTH;
  localparam int DW = mem_in.DATA_WIDTH;
  localparam int MW = mem_in.MASK_WIDTH;
  localparam int IW = mem_in.ID_WIDTH;
  localparam int CW = $clog2(OUTPUT_DEPTH + 1);
  localparam int PW = $clog2(OUTPUT_DEPTH);

  if (mem_in.ADDR_WIDTH != mem_out.ADDR_WIDTH || mem_in.DATA_WIDTH != mem_out.DATA_WIDTH ||
      mem_in.ID_WIDTH != mem_out.ID_WIDTH || mem_in.MASK_WIDTH != mem_out.MASK_WIDTH) begin : g_width_check
    $error("mem_in and mem_out widths differ");
  end
  if (DW % MW != 0) begin : g_lane_check
    $error("DATA_WIDTH must be a multiple of MASK_WIDTH");
  end
  if (OUTPUT_DEPTH < 2) begin : g_depth_check
    $error("OUTPUT_DEPTH must be at least 2");
  end

  typedef struct packed {
    logic          read_enable;
    logic [MW-1:0] write_enable;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } resp_t;

  logic          accept, responds, push, pop;
  logic [CW-1:0] fifo_count, credit_count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  resp_t         fifo_mem [OUTPUT_DEPTH];
  resp_t         p_resp, head;

  logic          p_valid, p_read;
  logic [MW-1:0] p_we;
  logic [AW-1:0] p_addr;
  logic [IW-1:0] p_id;
  logic [DW-1:0] ram_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTPUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every response in P or the FIFO holds a credit, so a push always finds room.
  assign credit_count = CW'(p_valid) + fifo_count;
  assign mem_in.ready = !rst && (credit_count < CW'(OUTPUT_DEPTH));
  assign accept       = mem_in.valid && mem_in.ready;
  assign responds     = mem_in.read_enable || (WRITE_RESPOND && (|mem_in.write_enable));
  assign push         = p_valid;
  assign pop          = mem_out.valid && mem_out.ready;

  mem_block_ram_array #(
    .CLOCK_INFO (CLOCK_INFO),
    .READ_MODE  (READ_FIRST),
    .WIDTH      (DW),
    .DEPTH      (1 << AW),
    .LANES      (MW),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (accept),
    .we    (mem_in.write_enable & {MW{accept}}),
    .addr  (mem_in.addr),
    .wdata (mem_in.data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
    end else begin
      p_valid <= accept && responds;
    end
    if (accept) begin
      p_read <= mem_in.read_enable;
      p_we   <= mem_in.write_enable;
      p_addr <= mem_in.addr;
      p_id   <= mem_in.id;
    end
  end

  assign p_resp = '{read_enable:  p_read,
                    write_enable: p_we,
                    addr:         p_addr,
                    data:         p_read ? ram_q : '0,
                    id:           p_id};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= p_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign head                 = fifo_mem[rd_ptr];
  assign mem_out.valid        = (fifo_count != '0);
  assign mem_out.read_enable  = head.read_enable;
  assign mem_out.write_enable = head.write_enable;
  assign mem_out.addr         = head.addr;
  assign mem_out.data         = head.data;
  assign mem_out.id           = head.id;
endmodule
